// File: rtl/uart_tx_fc.sv
// Flow-controlled 8N1/8N2 UART transmitter with a byte FIFO on a valid/ready input.
// A new frame launches only while the peer grants permission on peer_rts_n.
module uart_tx_fc #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD_RATE   = 2_000_000,
    parameter int FIFO_DEPTH  = 16,
    parameter int STOP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in_data,
    input  logic                          byte_in_valid,
    output logic                          byte_in_ready,
    input  logic                          peer_rts_n,
    output logic                          bit_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    // state | meaning
    // IDLE  | line high, waiting for a queued byte and peer permission
    // START | start bit (low) for one bit period
    // DATA  | eight data bits, LSB first
    // STOP  | stop period (high); last cycle may launch the next frame

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int CW           = $clog2(STOP_CLKS);

    localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST  = CW'(STOP_CLKS - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fc: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fc: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx_fc: STOP_BITS must be 1 or 2");
    end

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;
    logic          bit_done;
    logic          stop_done;
    logic          frame_slot;
    logic          launch;

    assign fifo_empty    = (level == '0);
    assign fifo_full     = (level == FULL_LEVEL);
    assign byte_in_ready = !fifo_full && !rst;
    assign push          = byte_in_valid && byte_in_ready;
    assign head          = mem[rd_ptr];

    assign bit_done   = (cnt == BIT_LAST);
    assign stop_done  = (cnt == STOP_LAST);
    // peer permission is looked at only here, so a mid-frame change never cuts a frame short
    assign frame_slot = (state == ST_IDLE) || ((state == ST_STOP) && stop_done);
    assign launch     = frame_slot && !fifo_empty && !peer_rts_n;
    assign pop        = launch;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= byte_in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shifter <= '0;
            bit_out <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt <= '0;
                    if (launch) begin
                        shifter <= head;
                        bit_out <= 1'b0;
                        state   <= ST_START;
                    end else begin
                        bit_out <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_done) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        bit_out <= shifter[0];
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_done) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_out <= 1'b1;
                            state   <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shifter <= shifter >> 1;
                            bit_out <= shifter[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (stop_done) begin
                        cnt <= '0;
                        if (launch) begin
                            shifter <= head;
                            bit_out <= 1'b0;
                            state   <= ST_START;
                        end else begin
                            bit_out <= 1'b1;
                            state   <= ST_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt     <= '0;
                    bit_out <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign fifo_level = level;

endmodule

// File: doc/uart_tx_fc.md
# uart_tx_fc

Flow-controlled UART transmitter for the board-level serial link; the transmit-direction counterpart to the RTS/CTS-capable receive path. Bytes arrive on a valid/ready stream into an internal FIFO and are serialised 8N1 (or 8N2) on `bit_out`. A new frame starts only while the peer grants permission on `peer_rts_n`. It sits between on-chip byte producers (debug/loopback logic) and the TXD output buffer.

## Interface
- `CLK_FREQ_HZ`, 100_000_000, clock frequency in Hz.
- `BAUD_RATE`, 2_000_000, line rate in bit/s.
  - `CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE`, using integer division.
  - `CLKS_PER_BIT` must be ≥ 2; otherwise elaboration fails.
- `FIFO_DEPTH`, 16, FIFO entries. Must be a power of 2 and ≥ 2; otherwise elaboration fails.
- `STOP_BITS`, 1, stop bits per frame. Must be 1 or 2; otherwise elaboration fails.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `byte_in_data`  in  8  byte to send.
- `byte_in_valid`  in  1  producer has a byte.
- `byte_in_ready`  out  1  FIFO can accept a byte.
- `peer_rts_n`  in  1  peer ready to receive, active low. Already synchronised to `clk` by the instantiator.
- `bit_out`  out  1  serial TXD; idles high.
- `busy`  out  1  a frame is in progress.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  bytes currently held in the FIFO.

## Operation
- **FIFO**
  - Push on a clock edge with `byte_in_valid && byte_in_ready`.
  - `byte_in_ready = (fifo_level != FIFO_DEPTH) && !rst`.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - A push and a pop on the same edge leave `fifo_level` unchanged.
  - A pop never occurs on an empty FIFO.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE**
    - If FIFO is non-empty and `peer_rts_n == 0`: pop the head into the shift register, drive `bit_out = 0`, go to START.
    - Otherwise stay; `bit_out = 1`.
  - **START:** hold 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - **DATA**
    - 8 bits, LSB first, each held `CLKS_PER_BIT` cycles.
    - A 3-bit bit index and a baud counter count from 0 to `CLKS_PER_BIT-1`.
    - After bit 7, go to STOP.
  - **STOP:** hold 1 for `STOP_BITS*CLKS_PER_BIT` cycles. On the last cycle, apply the IDLE launch condition:
    - If it holds, pop and go directly to START, with no idle gap.
    - Otherwise go to IDLE.
- **Flow control**
  - `peer_rts_n` is sampled only at frame launch.
  - Deassertion mid-frame never truncates a frame; the current frame completes with its full stop period.
- `busy` = FSM state != IDLE.
- Frame length is exactly `(9+STOP_BITS)*CLKS_PER_BIT` cycles.
- `bit_out` is driven from a flop (glitch-free).

## Timing
- **Reset values** (asserted asynchronously, held while `rst` is high):
  - `bit_out = 1`, `busy = 0`, `fifo_level = 0`, `byte_in_ready = 0`.
  - FSM in IDLE; counters 0.
- After reset release, `byte_in_ready = 1`.
- **Latency:** a byte accepted at edge E into an empty FIFO with the FSM idle and `peer_rts_n = 0` gives:
  - `fifo_level = 1` after E;
  - `bit_out` falls and `busy` rises at edge E+1;
  - `fifo_level` returns to 0 at E+1, unless a push also occurs on E+1.
- **Full:** at `fifo_level == FIFO_DEPTH`, `byte_in_ready = 0` the same cycle. A pop at edge P re-asserts `byte_in_ready` after P.
- **Reset mid-frame:** `bit_out` returns to 1 immediately, FIFO contents are discarded, and the partial frame is lost. No recovery is required.
- **Back-to-back frames:** the start bit of frame N+1 begins on the cycle after the last stop cycle of frame N.

## Test plan
- **Single byte:** defaults, `peer_rts_n = 0`, push 0xA5.
  - `bit_out` reads 0,1,0,1,0,0,1,0,1,1, each level held 50 cycles (500-cycle frame).
  - `busy` is high for exactly 500 cycles.
  - Start bit appears 1 cycle after the handshake edge.
- **Burst:** push 0x00, 0xFF, 0x3C back-to-back.
  - Three contiguous frames, 1500 cycles total.
  - No idle-high cycles between stop and start.
  - `fifo_level` peaks at 2.
- **Full:** with `peer_rts_n = 1`, push 17 bytes (0x01..0x11).
  - `byte_in_ready` drops after the 16th push; `fifo_level = 16`; `bit_out` stays 1.
  - Release `peer_rts_n`: 16 frames 0x01..0x10 are sent in order, and the 17th byte is only accepted after the first pop.
- **Flow control mid-frame:** raise `peer_rts_n` 200 cycles into a frame with 2 bytes queued.
  - The current frame completes in full.
  - The next frame starts only 1 cycle after `peer_rts_n` returns to 0.
- **Reset mid-frame:** assert `rst` 5 ns into the DATA state with 3 bytes queued.
  - `bit_out = 1` asynchronously; `fifo_level = 0`; `busy = 0`.
  - After release, no frame is emitted.
- **STOP_BITS=2, CLKS_PER_BIT=4:** push 0x81.
  - 44-cycle frame; the stop level is held 8 cycles.
  - `bit_out` pattern: 0,1,0,0,0,0,0,0,1,1,1.
